trig_unit_arbiter: RTL and testbench

//   Shares one sine core (9-bit degree in, 32-bit signed amplitude out, start/done) among
//   NUM_REQ requesters, e.g. the orientation-vector calculators fed by the gyro integrator.

---
 rtl/trig_unit_arbiter_if.sv | 27 ++
 rtl/trig_unit_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_trig_unit_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_unit_arbiter_if.sv
// Requester-side bus of the shared sine-core arbiter.
// The slave modport is the arbiter; the master modport is the requester
// cluster (orientation-vector calculators or a testbench).
`timescale 1ns/1ps

interface trig_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AMP_W   = 32
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*9-1:0]    req_angle;
    logic [NUM_REQ-1:0]      req_cos;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic signed [AMP_W-1:0] rsp_amp;
    logic                    rsp_err;

    modport master (
        output req_valid, req_angle, req_cos,
        input  req_ready, rsp_valid, rsp_amp, rsp_err
    );

    modport slave (
        input  req_valid, req_angle, req_cos,
        output req_ready, rsp_valid, rsp_amp, rsp_err
    );
endinterface

// File: rtl/trig_unit_arbiter.sv
// trig_unit_arbiter
// Shares one sine core among NUM_REQ requesters. Requests are granted
// round-robin, the angle is folded into 0..359 (cosine served as sin(90-a)),
// and the core result is returned as a one-cycle strobe to the owner.
// Only one transaction is in flight at a time.
//
// Optional feature: define TRIG_ARB_TIMEOUT_EN to enable a WAIT watchdog.
// The response then arrives TIMEOUT_CYCLES cycles after the start pulse with
// rsp_amp = 0 and rsp_err = 1 if the core never signals done. Without the
// macro the arbiter waits for the core indefinitely and rsp_err is tied low.
`timescale 1ns/1ps

module trig_unit_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AMP_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_in,
    trig_unit_arbiter_if.slave      req_bus,
    output logic                    busy,
    output logic                    sine_start,
    output logic [8:0]              sine_value,
    input  logic                    sine_done,
    input  logic signed [AMP_W-1:0] sine_amp
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner_id;
    logic [PTR_W-1:0]  grant_id;
    logic              grant_found;
    logic [8:0]        grant_angle;
    logic              grant_cos;
    logic signed [9:0] angle_wrapped;
    logic signed [9:0] angle_final;
    logic              timeout_hit;

    // Requester index reached by stepping 'offset' places from 'base', wrapping at NUM_REQ.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    // Round-robin search: first valid requester starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_bus.req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_idx(rr_ptr, k);
            end
        end
    end

    // Fold the granted angle into 0..359 and convert cosine requests to 90-a.
    // Done at grant time so sine_value is already registered in the start cycle.
    always_comb begin
        grant_angle   = req_bus.req_angle[9*int'(grant_id) +: 9];
        grant_cos     = req_bus.req_cos[grant_id];
        angle_wrapped = $signed({1'b0, grant_angle});
        if (grant_angle >= 9'd360) begin
            angle_wrapped = $signed({1'b0, grant_angle}) - 10'sd360;
        end
        angle_final = angle_wrapped;
        if (grant_cos) begin
            angle_final = 10'sd90 - angle_wrapped;
            if (angle_final < 10'sd0) begin
                angle_final = angle_final + 10'sd360;
            end
        end
    end

`ifdef TRIG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_flag;

    // Counts cycles since the start pulse; the start cycle itself counts as one,
    // so the response lands exactly TIMEOUT_CYCLES cycles after sine_start.
    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= CNT_W'(1);
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == ST_WAIT) && !sine_done &&
                         (wait_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Remember whether the transaction ended by watchdog rather than by the core.
    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            err_flag <= 1'b0;
        end else if (state == ST_WAIT) begin
            err_flag <= timeout_hit;
        end
    end

    assign req_bus.rsp_err = err_flag && (state == ST_RESPOND);
`else
    // Watchdog compiled out: the limit is never reached for any legal TIMEOUT_CYCLES.
    assign timeout_hit     = (TIMEOUT_CYCLES < 0);
    assign req_bus.rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (sine_done || timeout_hit) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One-hot accept (IDLE only, masked during reset) and one-hot response strobe.
    always_comb begin
        req_bus.req_ready = '0;
        req_bus.rsp_valid = '0;
        if ((state == ST_IDLE) && grant_found && !rst_in) begin
            req_bus.req_ready[grant_id] = 1'b1;
        end
        if (state == ST_RESPOND) begin
            req_bus.rsp_valid[owner_id] = 1'b1;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign sine_start = (state == ST_ISSUE);

    // Transaction datapath: owner and core angle captured at accept, result
    // captured from the core in WAIT, pointer advanced past the owner on response.
    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            owner_id        <= '0;
            sine_value      <= '0;
            req_bus.rsp_amp <= '0;
            rr_ptr          <= '0;
        end else begin
            if ((state == ST_IDLE) && grant_found) begin
                owner_id   <= grant_id;
                sine_value <= angle_final[8:0];
            end
            if (state == ST_WAIT) begin
                if (sine_done) begin
                    req_bus.rsp_amp <= sine_amp;
                end else if (timeout_hit) begin
                    req_bus.rsp_amp <= '0;
                end
            end
            if (state == ST_RESPOND) begin
                if (owner_id == PTR_W'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= owner_id + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_trig_unit_arbiter.sv
// Testbench for trig_unit_arbiter: acts as requesters and as the sine core,
// predicts core angles and responses into queues, and checks them as the
// DUT produces sine_start and rsp_valid.
`timescale 1ns/1ps

module tb_trig_unit_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int AMP_W          = 32;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct {
        int                      id;
        logic signed [AMP_W-1:0] amp;
        logic                    err;
    } rsp_exp_t;

    logic                    clk_100mhz = 1'b0;
    logic                    rst_in;
    logic                    busy;
    logic                    sine_start;
    logic [8:0]              sine_value;
    logic                    sine_done;
    logic signed [AMP_W-1:0] sine_amp;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;
    int          core_lat     = 1;
    bit          core_en      = 1'b1;
    int          core_cnt     = 0;
    logic [8:0]  core_val;
    rsp_exp_t    rsp_q[$];
    logic [8:0]  val_q[$];
    int          rsp_cycles[$];
    int          last_start_cyc = 0;
    int          last_rsp_cyc   = 0;
    int          acc_cyc        = 0;
    rsp_exp_t    mon_exp;
    int          t2_angle[10];
    bit          t2_cos[10];
    int          t2_exp[10];
    int          order[5];

    trig_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .AMP_W(AMP_W)) bus ();

    trig_unit_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .AMP_W          (AMP_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_in     (rst_in),
        .req_bus    (bus),
        .busy       (busy),
        .sine_start (sine_start),
        .sine_value (sine_value),
        .sine_done  (sine_done),
        .sine_amp   (sine_amp)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Free-running cycle count used for latency measurements.
    initial begin
        forever begin
            @(posedge clk_100mhz);
            cyc = cyc + 1;
        end
    end

    // Stand-in sine core result: arbitrary but distinct per angle, with sign bits exercised.
    function automatic logic signed [AMP_W-1:0] coreAmp(input logic [8:0] v);
        return $signed({v[3:0], 10'h2A5, 9'h000, v});
    endfunction

    // Sine core model: done core_lat cycles after start, garbage on sine_amp otherwise.
    initial begin
        sine_done = 1'b0;
        sine_amp  = 32'shDEADBEEF;
        fork
            forever begin
                @(negedge clk_100mhz);
                if (sine_start === 1'b1) begin
                    core_cnt = core_lat;
                    core_val = sine_value;
                end
            end
            forever begin
                @(posedge clk_100mhz);
                #1;
                sine_done = 1'b0;
                sine_amp  = 32'shDEADBEEF;
                if (core_cnt > 0) begin
                    core_cnt = core_cnt - 1;
                    if (core_cnt == 0 && core_en) begin
                        sine_done = 1'b1;
                        sine_amp  = coreAmp(core_val);
                    end
                end
            end
        join
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run = tests_run + 1;
        assert (observed === expected) else begin
            tests_failed = tests_failed + 1;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expectTxn(input int id, input logic [8:0] val, input bit err);
        rsp_exp_t e;
        e.id  = id;
        e.err = err;
        e.amp = err ? '0 : coreAmp(val);
        val_q.push_back(val);
        rsp_q.push_back(e);
    endtask

    // Single requester: raise valid, hold until accepted, then drop.
    task automatic applyStimulus(input int id, input logic [8:0] angle, input bit cos_sel);
        int waited;
        bus.req_angle[9*id +: 9] = angle;
        bus.req_cos[id]          = cos_sel;
        bus.req_valid[id]        = 1'b1;
        waited = 0;
        do begin
            @(negedge clk_100mhz);
            waited = waited + 1;
        end while (bus.req_ready === '0 && waited < 50);
        checkOutput("req_ready", 64'(bus.req_ready), 64'(1) << id);
        acc_cyc = cyc;
        @(posedge clk_100mhz);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic waitGrant(input int exp_id, input string tag);
        int waited;
        waited = 0;
        do begin
            @(negedge clk_100mhz);
            waited = waited + 1;
        end while (bus.req_ready === '0 && waited < 50);
        checkOutput(tag, 64'(bus.req_ready), 64'(1) << exp_id);
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk_100mhz);
            n = n + 1;
        end
        checkOutput("drain", 64'(rsp_q.size()), 64'd0);
        rsp_q.delete();
        val_q.delete();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic pulseReset();
        @(posedge clk_100mhz);
        #1;
        rst_in = 1'b1;
        @(posedge clk_100mhz);
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in        = 1'b1;
        bus.req_valid = '0;
        bus.req_angle = '0;
        bus.req_cos   = '0;
        t2_angle = '{0, 200, 400, 450, 359, 360, 511, 91, 90, 30};
        t2_cos   = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 1};
        t2_exp   = '{90, 250, 40, 0, 359, 0, 151, 359, 0, 60};

        // Monitor: core angle at each start, scoreboard pop at each response.
        fork
            forever begin
                @(negedge clk_100mhz);
                if (sine_start === 1'b1) begin
                    last_start_cyc = cyc;
                    if (val_q.size() == 0) begin
                        checkOutput("unexpected_start", 64'(sine_start), 64'd0);
                    end else begin
                        checkOutput("sine_value", 64'(sine_value), 64'(val_q.pop_front()));
                    end
                end
                if (bus.rsp_valid !== '0) begin
                    last_rsp_cyc = cyc;
                    rsp_cycles.push_back(cyc);
                    if (rsp_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                    end else begin
                        mon_exp = rsp_q.pop_front();
                        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(1) << mon_exp.id);
                        checkOutput("rsp_amp", 64'(bus.rsp_amp), 64'(mon_exp.amp));
                        checkOutput("rsp_err", 64'(bus.rsp_err), 64'(mon_exp.err));
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_amp", 64'(bus.rsp_amp), 64'd0);
        checkOutput("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        checkOutput("rst_sine_start", 64'(sine_start), 64'd0);
        checkOutput("rst_sine_value", 64'(sine_value), 64'd0);
        @(posedge clk_100mhz);
        #1;
        rst_in = 1'b0;

        // Single sine request with minimum core latency.
        core_lat = 1;
        expectTxn(0, 9'd30, 1'b0);
        applyStimulus(0, 9'd30, 1'b0);
        waitDrain(50);
        checkOutput("t1_latency", 64'(last_rsp_cyc - acc_cyc), 64'd3);
        @(negedge clk_100mhz);
        checkOutput("t1_amp_hold", 64'(bus.rsp_amp), 64'(coreAmp(9'd30)));
        checkOutput("t1_idle", 64'(busy), 64'd0);
        @(posedge clk_100mhz);
        #1;

        // Angle normalisation table, varied requester and core latency.
        for (int k = 0; k < 10; k++) begin
            core_lat = 1 + (k % 3);
            expectTxn(k % NUM_REQ, 9'(t2_exp[k]), 1'b0);
            applyStimulus(k % NUM_REQ, 9'(t2_angle[k]), t2_cos[k]);
            waitDrain(50);
        end

        // All four requesters held valid from reset: strict round-robin, back-to-back.
        core_lat = 1;
        @(posedge clk_100mhz);
        #1;
        rst_in        = 1'b1;
        bus.req_angle = {9'd300, 9'd200, 9'd100, 9'd10};
        bus.req_cos   = 4'b1000;
        bus.req_valid = 4'b1111;
        @(negedge clk_100mhz);
        checkOutput("t3_ready_in_reset", 64'(bus.req_ready), 64'd0);
        checkOutput("t3_busy_in_reset", 64'(busy), 64'd0);
        order = '{0, 1, 2, 3, 0};
        expectTxn(0, 9'd10, 1'b0);
        expectTxn(1, 9'd100, 1'b0);
        expectTxn(2, 9'd200, 1'b0);
        expectTxn(3, 9'd150, 1'b0);
        expectTxn(0, 9'd10, 1'b0);
        rsp_cycles.delete();
        @(posedge clk_100mhz);
        #1;
        rst_in = 1'b0;
        for (int n = 0; n < 5; n++) begin
            waitGrant(order[n], "t3_grant");
        end
        @(posedge clk_100mhz);
        #1;
        bus.req_valid = '0;
        waitDrain(50);
        checkOutput("t3_rsp_count", 64'(rsp_cycles.size()), 64'd5);
        for (int i = 1; i < rsp_cycles.size(); i++) begin
            checkOutput("t3_spacing", 64'(rsp_cycles[i] - rsp_cycles[i-1]), 64'd4);
        end

        // Requesters 0 and 3 permanently valid: grants alternate.
        pulseReset();
        bus.req_angle = {9'd359, 9'd0, 9'd0, 9'd5};
        bus.req_cos   = 4'b1000;
        order = '{0, 3, 0, 3, 0};
        expectTxn(0, 9'd5, 1'b0);
        expectTxn(3, 9'd91, 1'b0);
        expectTxn(0, 9'd5, 1'b0);
        expectTxn(3, 9'd91, 1'b0);
        bus.req_valid = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            waitGrant(order[n], "t4_grant");
        end
        @(posedge clk_100mhz);
        #1;
        bus.req_valid = '0;
        waitDrain(50);

        // Reset during WAIT drops the transaction and returns rr_ptr to 0.
        bus.req_cos = '0;
        expectTxn(1, 9'd120, 1'b0);
        applyStimulus(1, 9'd120, 1'b0);
        waitDrain(50);
        core_lat = 10;
        val_q.push_back(9'd250);
        applyStimulus(2, 9'd250, 1'b0);
        @(posedge clk_100mhz);
        #1;
        rst_in = 1'b1;
        @(negedge clk_100mhz);
        checkOutput("t5_busy", 64'(busy), 64'd0);
        checkOutput("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("t5_rsp_amp", 64'(bus.rsp_amp), 64'd0);
        checkOutput("t5_sine_value", 64'(sine_value), 64'd0);
        @(posedge clk_100mhz);
        #1;
        rst_in = 1'b0;
        repeat (12) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        checkOutput("t5_late_done_ignored", 64'(busy), 64'd0);
        @(posedge clk_100mhz);
        #1;
        core_lat = 1;
        bus.req_angle = {9'd25, 9'd0, 9'd15, 9'd0};
        expectTxn(1, 9'd15, 1'b0);
        expectTxn(3, 9'd25, 1'b0);
        bus.req_valid = 4'b1010;
        waitGrant(1, "t5_grant_after_reset");
        waitGrant(3, "t5_grant_second");
        @(posedge clk_100mhz);
        #1;
        bus.req_valid = '0;
        waitDrain(50);

        // Core never answers.
        core_en = 1'b0;
`ifdef TRIG_ARB_TIMEOUT_EN
        expectTxn(2, 9'd45, 1'b1);
        applyStimulus(2, 9'd45, 1'b0);
        waitDrain(60);
        checkOutput("t6_timeout_latency", 64'(last_rsp_cyc - last_start_cyc), 64'(TIMEOUT_CYCLES));
`else
        val_q.push_back(9'd45);
        applyStimulus(2, 9'd45, 1'b0);
        repeat (40) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        checkOutput("t6_busy_hold", 64'(busy), 64'd1);
        checkOutput("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
        pulseReset();
`endif
        core_en = 1'b1;
        repeat (3) @(posedge clk_100mhz);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
